// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered UART transmitter with optional parity and 1/2 stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int BAUD_DIV   = 868,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [DATA_BITS-1:0]        wr_data,
   input  logic                        clr_ovf,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        busy,
   output logic                        overflow,
   output logic                        tx_done,
   output logic                        Tx
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_BW = $clog2(BAUD_DIV);
   localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUD_DIV - 1);
   localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
   localparam logic [3:0]      c_LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic            c_LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic            c_ODD       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]       r_wptr, r_rptr;
   logic [c_AW:0]         r_level;
   logic                  r_ovf;
   logic [c_BW-1:0]       r_baud;
   logic [DATA_BITS-1:0]  r_shift;
   logic [3:0]            r_bitcnt;
   logic                  r_stopcnt;
   logic                  r_par;
   logic                  r_tx, r_done;
   logic                  w_push, w_pop, w_bit_end, w_tx_nxt, w_done_nxt;
   logic [DATA_BITS-1:0]  w_head;

   assign full      = (r_level == c_FULL);
   assign empty     = (r_level == '0);
   assign level     = r_level;
   assign overflow  = r_ovf;
   assign busy      = (r_state != S_IDLE);
   assign tx_done   = r_done;
   assign Tx        = r_tx;
   assign w_push    = wr_en && !full;
   assign w_head    = r_mem[r_rptr];
   assign w_bit_end = (r_baud == c_BAUD_LAST);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= wr_data;
   end

   // A full FIFO drops the write even when the FSM pops in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (c_AW + 1)'(1);
            2'b01:   r_level <= r_level - (c_AW + 1)'(1);
            default: r_level <= r_level;
         endcase
         if (wr_en && full) r_ovf <= 1'b1;
         else if (clr_ovf)  r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Tx is registered from the current state, so the line lags the FSM by one clock.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (w_bit_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_bit_end && r_bitcnt == c_LAST_BIT)
               w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            w_tx_nxt = r_par;
            if (w_bit_end) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_bit_end && r_stopcnt == c_LAST_STOP) begin
               w_done_nxt = 1'b1;
               if (!empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_baud    <= '0;
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_stopcnt <= 1'b0;
         r_par     <= 1'b0;
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_done <= w_done_nxt;
         if (w_pop) begin
            r_shift   <= w_head;
            r_par     <= (^w_head) ^ c_ODD;
            r_baud    <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
         end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
               r_baud <= '0;
               if (r_state == S_DATA) begin
                  r_shift  <= r_shift >> 1;
                  r_bitcnt <= r_bitcnt + 4'd1;
               end
               if (r_state == S_STOP) r_stopcnt <= r_stopcnt + 1'b1;
            end else begin
               r_baud <= r_baud + c_BW'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo (two parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int BAUD = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_reset, a_wr, a_clr;
   logic [7:0] a_data;
   logic       a_full, a_empty, a_busy, a_ovf, a_done, a_tx;
   logic [2:0] a_level;

   logic       b_reset, b_wr, b_clr;
   logic [6:0] b_data;
   logic       b_full, b_empty, b_busy, b_ovf, b_done, b_tx;
   logic [2:0] b_level;

   int n_vec, n_err;

   uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .reset(a_reset), .wr_en(a_wr), .wr_data(a_data), .clr_ovf(a_clr),
      .full(a_full), .empty(a_empty), .level(a_level), .busy(a_busy),
      .overflow(a_ovf), .tx_done(a_done), .Tx(a_tx));

   uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .reset(b_reset), .wr_en(b_wr), .wr_data(b_data), .clr_ovf(b_clr),
      .full(b_full), .empty(b_empty), .level(b_level), .busy(b_busy),
      .overflow(b_ovf), .tx_done(b_done), .Tx(b_tx));

   typedef struct {
      logic       rst;
      logic       wr;
      logic [7:0] data;
      logic       clr;
      logic [2:0] level;
      logic       empty, full, ovf, busy, tx, done;
   } vec_t;

   vec_t vt[13];
   logic [7:0] wd[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic get_tx(input int sel);
      return (sel == 0) ? a_tx : b_tx;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 0) ? a_done : b_done;
   endfunction

   // Expects the next sample to be the first clock of the start bit.
   task automatic capture_frame(input int sel, input logic [8:0] data);
      logic exp_bits[16];
      int   nb, db, sb;
      logic p;
      if (sel == 0) begin db = 8; sb = 1; p = 1'b0; end
      else          begin db = 7; sb = 2; p = 1'b1; end
      nb = 0;
      exp_bits[nb] = 1'b0; nb++;
      for (int i = 0; i < db; i++) begin
         exp_bits[nb] = data[i]; nb++;
         p ^= data[i];
      end
      exp_bits[nb] = p; nb++;
      for (int i = 0; i < sb; i++) begin exp_bits[nb] = 1'b1; nb++; end
      for (int b = 0; b < nb; b++) begin
         for (int s = 0; s < BAUD; s++) begin
            step();
            check($sformatf("dut%0d data %h bit %0d tx", sel, data, b), 32'(get_tx(sel)), 32'(exp_bits[b]));
            check($sformatf("dut%0d data %h bit %0d tx_done", sel, data, b), 32'(get_done(sel)),
                  32'((b == nb - 1) && (s == BAUD - 1)));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic bad;
      int   t;
      n_vec = 0; n_err = 0;
      a_reset = 1'b0; a_wr = 1'b0; a_data = '0; a_clr = 1'b0;
      b_reset = 1'b0; b_wr = 1'b0; b_data = '0; b_clr = 1'b0;

      //           rst   wr    data   clr  | level empty full  ovf   busy  tx    done
      vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 8'h22, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 8'h33, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 8'h44, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 8'h55, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 8'h66, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 8'h77, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      for (int i = 0; i < 13; i++) begin
         a_reset = vt[i].rst; a_wr = vt[i].wr; a_data = vt[i].data; a_clr = vt[i].clr;
         step();
         check($sformatf("vector %0d {level,empty,full,ovf,busy,tx,done}", i),
               32'({a_level, a_empty, a_full, a_ovf, a_busy, a_tx, a_done}),
               32'({vt[i].level, vt[i].empty, vt[i].full, vt[i].ovf, vt[i].busy, vt[i].tx, vt[i].done}));
      end
      a_wr = 1'b0; a_clr = 1'b0;
      b_reset = 1'b1;

      // Single frame 0x55 with write-to-start latency.
      a_wr = 1'b1; a_data = 8'h55; step(); a_wr = 1'b0;
      step();
      check("basic latency tx", 32'(a_tx), 32'(1'b1));
      capture_frame(0, 9'h055);
      step();
      check("basic end {tx,busy,empty,done}", 32'({a_tx, a_busy, a_empty, a_done}), 32'(4'b1010));

      // Back-to-back frames.
      a_wr = 1'b1; a_data = 8'hA5; step();
      a_data = 8'h3C; step(); a_wr = 1'b0;
      check("b2b latency tx", 32'(a_tx), 32'(1'b1));
      capture_frame(0, 9'h0A5);
      capture_frame(0, 9'h03C);
      step();
      check("b2b end {tx,busy,empty,done}", 32'({a_tx, a_busy, a_empty, a_done}), 32'(4'b1010));

      // Wrap-around streaming of 3 x depth frames.
      for (int k = 0; k < 12; k++) wd[k] = 8'(k * 29 + 7);
      a_wr = 1'b1; a_data = wd[0]; step();
      fork
         begin : writer
            a_data = wd[1]; step();
            a_data = wd[2]; step(); a_wr = 1'b0;
            check("wrap initial level", 32'(a_level), 32'(3'd2));
            for (int k = 3; k < 12; k++) begin
               t = 0;
               while (a_done !== 1'b1 && t < 200) begin step(); t++; end
               check("wrap tx_done wait", 32'(a_done), 32'(1'b1));
               a_wr = 1'b1; a_data = wd[k]; step(); a_wr = 1'b0;
               check("wrap level in 1..3", 32'(a_level >= 3'd1 && a_level <= 3'd3), 32'(1'b1));
            end
         end
         begin : reader
            step();
            for (int k = 0; k < 12; k++) capture_frame(0, {1'b0, wd[k]});
         end
      join
      step();
      check("wrap drained {level,empty,busy,ovf}", 32'({a_level, a_empty, a_busy, a_ovf}),
            32'({3'd0, 1'b1, 1'b0, 1'b0}));

      // Reset during data bit 3 with two entries queued.
      a_wr = 1'b1; a_data = 8'hC3; step();
      a_data = 8'h5A; step();
      a_data = 8'h96; step(); a_wr = 1'b0;
      repeat (17) step();
      check("pre-reset {level,tx}", 32'({a_level, a_tx}), 32'({3'd2, 1'b0}));
      a_reset = 1'b0; step();
      check("mid-frame reset {tx,level,busy,empty,full}",
            32'({a_tx, a_level, a_busy, a_empty, a_full}), 32'({1'b1, 3'd0, 1'b0, 1'b1, 1'b0}));
      a_reset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (a_tx !== 1'b1 || a_busy !== 1'b0) bad = 1'b1;
      end
      check("no stale frame after reset", 32'(bad), 32'(1'b0));

      // 7 data bits, odd parity, two stop bits.
      b_wr = 1'b1; b_data = 7'h00; step(); b_wr = 1'b0;
      step();
      check("options latency tx", 32'(b_tx), 32'(1'b1));
      capture_frame(1, 9'h000);
      step();
      check("options end {tx,busy,empty,done}", 32'({b_tx, b_busy, b_empty, b_done}), 32'(4'b1010));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUD_DIV, default 868: clocks per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 0: 1 = parity bit inserted after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16: FIFO entries; power of 2, at least 2.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  reset is synchronous and active-low (asserted when 0, sampled on the clk rising edge).
REQ-009 wr_en  input  1  write strobe; one entry offered per cycle.
REQ-010 wr_data  input  DATA_BITS  frame payload; bit 0 is transmitted first.
REQ-011 clr_ovf  input  1  clears the overflow flag.
REQ-012 full  output  1  high when level equals FIFO_DEPTH.
REQ-013 empty  output  1  high when level equals 0.
REQ-014 level  output  $clog2(FIFO_DEPTH)+1  count of queued entries, excluding the frame in flight.
REQ-015 busy  output  1  high while the FSM is not in IDLE.
REQ-016 overflow  output  1  sticky flag: a write was dropped.
REQ-017 tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit.
REQ-018 Tx  output  1  registered serial line; idles high.

Function
REQ-019 FIFO write: wr_en=1 and full=0 stores wr_data; level and empty update on the same edge.
REQ-020 Write when full: wr_en=1 and full=1 drops the data and sets overflow, even if a pop occurs in the same cycle.
REQ-021 Overflow clear: clr_ovf=1 clears overflow; a simultaneous drop takes priority and leaves overflow set.
REQ-022 Simultaneous write and pop (full=0): level is unchanged; the read pointer and write pointer each advance.
REQ-023 Pointers: the read and write pointers wrap modulo FIFO_DEPTH without gaps; level never exceeds FIFO_DEPTH and never underflows.
REQ-024 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-025 IDLE: on an edge where empty=0, the FSM pops the head entry into a shift register and enters START.
REQ-026 Latency: Tx drives the start bit low beginning 2 clock edges after the edge that accepted a write into an empty FIFO with the FSM idle.
REQ-027 Bit timing: every bit (start, data, parity, stop) holds Tx for exactly BAUD_DIV clocks, timed by a baud counter that reloads at each bit boundary.
REQ-028 DATA: transmits DATA_BITS bits LSB first, then enters PARITY if PARITY_EN=1, else STOP.
REQ-029 Parity bit: the XOR of the data bits, inverted when PARITY_ODD=1.
REQ-030 STOP: transmits STOP_BITS high bits; tx_done pulses during the final clock of the last stop bit.
REQ-031 Back-to-back frames: if empty=0 at the end of the stop period, the FSM pops and enters START with no idle cycle.
REQ-032 End of stream: if empty=1 at the end of the stop period, the FSM returns to IDLE with Tx high.
REQ-033 Frame length: each frame occupies (1 + DATA_BITS + PARITY_EN + STOP_BITS) * BAUD_DIV clocks.
REQ-034 Outputs are glitch-free; Tx changes only at bit boundaries.

Reset
REQ-035 Reset values while reset=0: Tx=1, busy=0, tx_done=0, overflow=0, level=0, empty=1, full=0, FSM=IDLE, pointers=0, baud counter=0.
REQ-036 Reset mid-frame: the frame is aborted, FIFO contents are discarded, and Tx=1 from the next edge.
REQ-037 Writes are ignored while reset=0.

Verification
REQ-038 Basic frame (BAUD_DIV=4, DATA_BITS=8, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1): write 0x55 -> Tx sequence 0,1,0,1,0,1,0,1,0,0,1, each bit held 4 clocks; frame is 44 clocks; tx_done pulses once.
REQ-039 Back-to-back: write 0xA5 and then 0x3C on consecutive cycles -> two contiguous frames; no high gap between the stop bit of the first frame and the start bit of the second; tx_done pulses twice, 44 clocks apart.
REQ-040 Fill and overflow (FIFO_DEPTH=4): 6 writes on consecutive cycles -> 5 entries accepted (one popped immediately into the FSM), full=1, level=4, overflow=1; a clr_ovf pulse clears overflow.
REQ-041 Wrap-around: 3 x FIFO_DEPTH frames streamed with level held between 1 and FIFO_DEPTH-1 -> bytes appear on Tx in write order; no loss; level returns to 0; empty=1 at the end.
REQ-042 Reset mid-frame: reset=0 during data bit 3 with 2 entries queued -> next edge gives Tx=1, level=0, busy=0; after release, no stale frame is transmitted.
REQ-043 Options (DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2): write 0x00 -> parity bit 1 and two stop bits; frame is 11*BAUD_DIV clocks.
